// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a registered winner index decoded to a one-hot grant.
// Optional tenure limit (HOLD_MAX cycles) is compiled in with `RR_ARB_HOLD_LIMIT_EN.
module rr_arbiter_8 #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx
);

  localparam int unsigned N    = 8;
  localparam int unsigned IDXW = 3;
  localparam int unsigned CNTW = 4;

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_GRANT = 1'b1;

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 16) begin : g_bad_hold_max
      $error("rr_arbiter_8: HOLD_MAX must lie in 1..16");
    end
  endgenerate

  // First set bit of v scanning p, p+1, ... modulo N; result is {found, index}.
  function automatic logic [IDXW:0] pick(input logic [IDXW-1:0] p, input logic [N-1:0] v);
    logic [IDXW:0]   r;
    logic [IDXW-1:0] k;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = p + IDXW'(i);
      if (v[k]) r = {1'b1, k};
    end
    return r;
  endfunction

  logic            r_state;
  logic            w_state_nxt;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] w_ptr_nxt;
  logic [IDXW-1:0] r_gnt_idx;
  logic [IDXW-1:0] w_idx_nxt;
  logic            r_gnt_valid;
  logic            w_valid_nxt;
  logic [IDXW:0]   w_pick_idle;
  logic [IDXW:0]   w_pick_next;
  logic [IDXW-1:0] w_idx_inc;
  logic            w_release;
  logic            w_rotate;

  assign w_idx_inc   = r_gnt_idx + IDXW'(1);
  assign w_pick_idle = pick(r_ptr, req);
  assign w_pick_next = pick(w_idx_inc, req & ~(N'(1) << r_gnt_idx));
  assign w_release   = !req[r_gnt_idx];

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_MAX - 1);

  logic [CNTW-1:0] r_hold_cnt;
  logic [CNTW-1:0] w_hold_nxt;

  // Forced rotation only when someone else is actually waiting.
  assign w_rotate = (r_hold_cnt == HOLD_LAST) && w_pick_next[IDXW];
`else
  assign w_rotate = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_gnt_idx;
    w_valid_nxt = r_gnt_valid;
`ifdef RR_ARB_HOLD_LIMIT_EN
    w_hold_nxt  = r_hold_cnt;
`endif
    if (!ena) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_idle[IDXW]) begin
            w_state_nxt = S_GRANT;
            w_idx_nxt   = w_pick_idle[IDXW-1:0];
            w_valid_nxt = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
            w_hold_nxt  = '0;
`endif
          end
        end
        S_GRANT: begin
          // Release and forced rotation both hand over without an idle bubble.
          if (w_release || w_rotate) begin
            w_ptr_nxt = w_idx_inc;
            if (w_pick_next[IDXW]) begin
              w_idx_nxt  = w_pick_next[IDXW-1:0];
`ifdef RR_ARB_HOLD_LIMIT_EN
              w_hold_nxt = '0;
`endif
            end else begin
              w_state_nxt = S_IDLE;
              w_valid_nxt = 1'b0;
            end
          end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
            if (r_hold_cnt != '1) w_hold_nxt = r_hold_cnt + CNTW'(1);
`endif
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      r_hold_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_gnt_valid <= w_valid_nxt;
`ifdef RR_ARB_HOLD_LIMIT_EN
      r_hold_cnt  <= w_hold_nxt;
`endif
    end
  end

  assign gnt       = {N{ena & r_gnt_valid}} & (N'(1) << r_gnt_idx);
  assign gnt_valid = r_gnt_valid;
  assign gnt_idx   = r_gnt_idx;

endmodule
